mbist_resp_checker: RTL
=======================

# mbist_resp_checker

Response-analysis end of the MBIST datapath: it consumes SRAM read data, compares it against the expected pattern produced by the MBIST data generator (`DATA_comp`), and accumulates a per-run pass/fail verdict. The verdict includes a sticky fail flag, a saturating fail count, the first-fail address and syndrome, and an optional failing-address log. It sits between the SRAM read port and the MBIST controller, which brackets each test run with `START` and `END_TEST`.

## Interface
- `DATA_W`, 8, SRAM word width
- `ADDR_W`, 8, SRAM address width
- `CNT_W`, 8, fail counter width
- `LOG_DEPTH`, 4, fail-log entries (power of two, ≥2; used only with `MBIST_FAIL_LOG_EN`)

- `CLK`  in  1  single clock; all state updates on rising edge
- `nRESET`  in  1  asynchronous, active-low reset
- `START`  in  1  one-cycle pulse: clear results, begin run
- `END_TEST`  in  1  one-cycle pulse: last read issued, finish run
- `CMP_EN`  in  1  read data valid this cycle
- `ADDR`  in  ADDR_W  address of the word on `DATA_SRAM`
- `DATA_SRAM`  in  DATA_W  SRAM read data
- `DATA_comp`  in  DATA_W  expected data
- `BUSY`  out  1  state is RUN or DRAIN
- `DONE`  out  1  state is DONE; results final
- `PASS`  out  1  `DONE & ~FAIL`
- `FAIL`  out  1  sticky: at least one mismatch this run
- `FAIL_CNT`  out  CNT_W  mismatch count, saturating
- `FAIL_ADDR`  out  ADDR_W  address of first mismatch
- `FAIL_SYN`  out  DATA_W  `DATA_SRAM ^ DATA_comp` of first mismatch
- `LOG_RD`  in  1  pop log head (macro only)
- `LOG_VALID`  out  1  log non-empty (macro only)
- `LOG_ADDR`  out  ADDR_W  log head address, first-word fall-through (macro only)
- `LOG_OVF`  out  1  sticky: mismatch dropped because log full (macro only)

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
  - IDLE/RUN/DRAIN/DONE + `START` → RUN.
  - RUN + `END_TEST` → DRAIN.
  - DRAIN → DONE unconditionally.
  - DONE holds until `START`.
- `START` clears `FAIL`, `FAIL_CNT`, `FAIL_ADDR`, `FAIL_SYN`, the log, `LOG_OVF`, and the stage-1 valid bit.
- `START` has priority over `END_TEST` when both are asserted in the same cycle.
- Stage 1 registers `CMP_EN`, `ADDR`, `DATA_SRAM` and `DATA_comp` when state is RUN; `CMP_EN` outside RUN is ignored. A `CMP_EN` coincident with `END_TEST` is accepted.
- Stage 2 checks the stage-1 word when its valid bit is set. A mismatch is `(DATA_SRAM ^ DATA_comp) != 0`. On a mismatch:
  - `FAIL` ← 1.
  - `FAIL_CNT` ← `FAIL_CNT + 1`, saturating at all-ones.
  - If `FAIL` was 0: `FAIL_ADDR` ← stage-1 address and `FAIL_SYN` ← syndrome. Later mismatches never overwrite them.
- All compare bits are significant; there is no masking.

## Timing
- Reset value of every output is 0. `LOG_ADDR` is 0 when the log is empty.
- `CMP_EN` sampled at edge N → `FAIL`/`FAIL_CNT`/`FAIL_ADDR`/`FAIL_SYN` updated after edge N+1 (2-stage latency).
- `END_TEST` sampled at edge N → DRAIN after N; DONE after N+1. The final compare (sampled at N) is reflected when `DONE` first rises.
- `START` at edge N → RUN after N. Results read 0 after N. A `CMP_EN` at N is not accepted (state was not RUN).
- `nRESET` asserted mid-run → immediate return to IDLE with all outputs 0. There is no partial-result retention.

## Configuration
- `MBIST_FAIL_LOG_EN` defined:
  - A `LOG_DEPTH`-entry FIFO pushes the address of every mismatch.
  - Push when full and no pop in the same cycle: entry dropped, `LOG_OVF` ← 1.
  - Push and pop in the same cycle when full: both succeed, no drop.
  - `LOG_RD` with `LOG_VALID`=0 is ignored.
  - Pops are allowed in any state.
- `MBIST_FAIL_LOG_EN` undefined: `LOG_*` ports and the FIFO are absent. Only first-fail capture and the counter remain.

## Test plan
- Reset: drive `nRESET`=0 with random inputs → all outputs 0 and state IDLE. After release, `CMP_EN` bursts without `START` leave `FAIL_CNT`=0.
- Clean run: `START`, then 16 `CMP_EN` cycles with `DATA_SRAM`=`DATA_comp`=0x55/0xAA alternating, then `END_TEST` → `DONE`=1 two edges later, `PASS`=1, `FAIL_CNT`=0.
- Single fault: mismatch at `ADDR`=0x05 with `DATA_SRAM`=0xF0, `DATA_comp`=0xFF → `FAIL` rises after edge N+1, `FAIL_ADDR`=0x05, `FAIL_SYN`=0x0F, `FAIL_CNT`=1, `PASS`=0 at DONE.
- Multiple faults plus edge case: mismatches at 0x03, 0x07, and at 0x09 coincident with `END_TEST` → `FAIL_ADDR`=0x03, `FAIL_CNT`=3 when `DONE` rises. A subsequent `START` clears all results.
- Saturation: `CNT_W`=4, 20 mismatches → `FAIL_CNT`=0xF.
- Log (macro on, `LOG_DEPTH`=4): mismatches at 0x10–0x15 with no pops → `LOG_OVF`=1, and four pops return 0x10, 0x11, 0x12, 0x13. A push+pop when full drops nothing.

Source files
------------

// File: rtl/mbist_resp_checker.sv
// MBIST response checker: two-stage compare of SRAM read data against expected data,
// accumulating a per-run verdict. Define MBIST_FAIL_LOG_EN to add the failing-address log FIFO.
module mbist_resp_checker #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              START,
  input  logic              END_TEST,
  input  logic              CMP_EN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_SRAM,
  input  logic [DATA_W-1:0] DATA_comp,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic              FAIL,
  output logic [CNT_W-1:0]  FAIL_CNT,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_SYN
`ifdef MBIST_FAIL_LOG_EN
  ,
  input  logic              LOG_RD,
  output logic              LOG_VALID,
  output logic [ADDR_W-1:0] LOG_ADDR,
  output logic              LOG_OVF
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  if (LOG_DEPTH < 2) begin : g_bad_depth
    $error("LOG_DEPTH must be at least 2");
  end

  logic [1:0]        state, state_n;
  logic              s1_vld;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_sram, s1_comp;
  logic [DATA_W-1:0] syn;
  logic              mism;
  logic              fail_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] syn_n;

  assign syn  = s1_sram ^ s1_comp;
  assign mism = s1_vld & (|syn);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  state_n = ST_IDLE;
      ST_RUN:   if (END_TEST) state_n = ST_DRAIN;
      ST_DRAIN: state_n = ST_DONE;
      ST_DONE:  state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
    if (START) state_n = ST_RUN;
  end

  // Stage-2 verdict update; first-fail capture only while FAIL is still clear
  always_comb begin
    fail_n = FAIL;
    cnt_n  = FAIL_CNT;
    addr_n = FAIL_ADDR;
    syn_n  = FAIL_SYN;
    if (START) begin
      fail_n = 1'b0;
      cnt_n  = '0;
      addr_n = '0;
      syn_n  = '0;
    end else if (mism) begin
      fail_n = 1'b1;
      if (FAIL_CNT != '1) cnt_n = FAIL_CNT + CNT_W'(1);
      if (!FAIL) begin
        addr_n = s1_addr;
        syn_n  = syn;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_CNT  <= '0;
      FAIL_ADDR <= '0;
      FAIL_SYN  <= '0;
    end else begin
      state     <= state_n;
      BUSY      <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      DONE      <= (state_n == ST_DONE);
      PASS      <= (state_n == ST_DONE) && !fail_n;
      FAIL      <= fail_n;
      FAIL_CNT  <= cnt_n;
      FAIL_ADDR <= addr_n;
      FAIL_SYN  <= syn_n;
    end
  end

  // Stage 1: read data accepted only in RUN; a START aborts any word in flight
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_sram <= '0;
      s1_comp <= '0;
    end else begin
      s1_vld <= (state == ST_RUN) && CMP_EN && !START;
      if (state == ST_RUN) begin
        s1_addr <= ADDR;
        s1_sram <= DATA_SRAM;
        s1_comp <= DATA_comp;
      end
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
  localparam int unsigned LCW   = PTR_W + 1;

  logic [ADDR_W-1:0] mem [LOG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LCW-1:0]    count, count_n;
  logic              ovf_n, log_push, log_pop, log_full, log_wr;
  logic [ADDR_W-1:0] head_n;

  assign log_full = (count == LCW'(LOG_DEPTH));
  assign log_push = mism && !START;
  assign log_pop  = LOG_RD && (count != '0) && !START;
  assign log_wr   = log_push && (!log_full || log_pop);

  // FIFO bookkeeping; head output is precomputed so LOG_ADDR stays registered
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    ovf_n    = LOG_OVF;
    if (START) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      ovf_n    = 1'b0;
    end else begin
      if (log_wr)  wr_ptr_n = wr_ptr + PTR_W'(1);
      if (log_pop) rd_ptr_n = rd_ptr + PTR_W'(1);
      if (log_wr && !log_pop)      count_n = count + LCW'(1);
      else if (!log_wr && log_pop) count_n = count - LCW'(1);
      if (log_push && log_full && !log_pop) ovf_n = 1'b1;
    end
    head_n = (log_wr && (rd_ptr_n == wr_ptr)) ? s1_addr : mem[rd_ptr_n];
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      LOG_OVF   <= 1'b0;
      LOG_VALID <= 1'b0;
      LOG_ADDR  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      LOG_OVF   <= ovf_n;
      LOG_VALID <= (count_n != '0);
      LOG_ADDR  <= (count_n != '0) ? head_n : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (log_wr) mem[wr_ptr] <= s1_addr;
  end
`endif

endmodule
